// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer.
// Holds the default geometry (entry count, address and data widths), the
// pointer width derived from the default depth, and the buffered entry
// record {valid, addr, data}. The entry record is sized by the package widths.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding match.
// Compares a load address against every valid buffer entry and returns the
// data of the youngest matching entry. Age runs from the head (oldest)
// towards the tail, so a later match in head-relative order overrides an
// earlier one.
// Ports:
//   entries_i  buffer storage (all DEPTH slots)
//   head_i     index of the oldest entry
//   addr_i     load address to compare
//   hit_o      any valid entry matched
//   data_o     data of the youngest matching entry (zero when no hit)
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PW    = SB_PTR_W
) (
    input  sb_entry          entries_i [DEPTH],
    input  logic [PW-1:0]    head_i,
    input  logic [SB_AW-1:0] addr_i,
    output logic             hit_o,
    output logic [SB_DW-1:0] data_o
);

    logic [PW-1:0] idx_s;

    // Walk oldest to youngest so the youngest match is the one left standing
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx_s  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = head_i + PW'(k);
            if (entries_i[idx_s].valid && (entries_i[idx_s].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx_s].data;
            end else begin
                hit_o  = hit_o;
                data_o = data_o;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the pipeline and a single-port data memory.
// Stores are queued in a circular FIFO and drained to memory one per cycle
// whenever the port is not claimed by a load. Loads are served by memory
// unless a buffered store to the same word exists, in which case the
// youngest buffered data is forwarded.
// Ports:
//   clkIn, resetIn          clock, synchronous active-high reset
//   StoreIn, LoadIn         pipeline requests; AddrIn/DataIn their operands
//   StallOut                request refused (buffer full), re-present later
//   LoadDataOut, LoadHitOut load result and forwarded flag
//   EmptyOut                no pending stores
//   MemAddrOut, MemDataOut, MemWriteOut, MemReadOut, MemDataIn  memory port
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clkIn,
    input  logic          resetIn,
    input  logic          StoreIn,
    input  logic          LoadIn,
    input  logic [AW-1:0] AddrIn,
    input  logic [DW-1:0] DataIn,
    output logic          StallOut,
    output logic [DW-1:0] LoadDataOut,
    output logic          LoadHitOut,
    output logic          EmptyOut,
    output logic [AW-1:0] MemAddrOut,
    output logic [DW-1:0] MemDataOut,
    output logic          MemWriteOut,
    output logic          MemReadOut,
    input  logic [DW-1:0] MemDataIn
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry       entry_q [DEPTH];
    sb_entry       entry_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full_s;
    logic          store_acc_s;
    logic          port_load_s;
    logic          load_fwd_s;
    logic          drain_s;
    logic          fwd_hit_s;
    logic [DW-1:0] fwd_data_s;

    // Request qualification and memory-port arbitration.
    // A raised LoadIn claims the port even alongside a store (the load itself
    // is ignored then), so stores can accumulate while the pipeline loads.
    // When full every request stalls and the port drains, so loads cannot
    // starve the buffer.
    always_comb begin
        full_s      = (count_q == CW'(DEPTH));
        StallOut    = full_s & (StoreIn | LoadIn);
        store_acc_s = StoreIn & ~full_s;
        port_load_s = LoadIn & ~full_s;
        load_fwd_s  = port_load_s & ~StoreIn;
        drain_s     = ~port_load_s & (count_q != '0);
        EmptyOut    = (count_q == '0);
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fwd (
        .entries_i (entry_q),
        .head_i    (head_q),
        .addr_i    (AddrIn),
        .hit_o     (fwd_hit_s),
        .data_o    (fwd_data_s)
    );

    // Memory port drive: load slot, head drain, or idle zeros
    always_comb begin
        MemAddrOut  = '0;
        MemDataOut  = '0;
        MemWriteOut = 1'b0;
        MemReadOut  = 1'b0;
        if (port_load_s) begin
            MemReadOut = 1'b1;
            MemAddrOut = AddrIn;
        end else if (drain_s) begin
            MemWriteOut = 1'b1;
            MemAddrOut  = entry_q[head_q].addr;
            MemDataOut  = entry_q[head_q].data;
        end else begin
            MemReadOut  = 1'b0;
            MemWriteOut = 1'b0;
        end
    end

    // Load result: forwarded buffer data on a hit, memory data otherwise.
    // The entry accepted this cycle is not yet valid, so it cannot match.
    always_comb begin
        LoadHitOut  = load_fwd_s & fwd_hit_s;
        LoadDataOut = MemDataIn;
        if (LoadHitOut) begin
            LoadDataOut = fwd_data_s;
        end else begin
            LoadDataOut = MemDataIn;
        end
    end

    // Next-state for pointers, occupancy and entry storage
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        entry_d = entry_q;
        if (drain_s) begin
            head_d                 = head_q + PW'(1);
            entry_d[head_q].valid  = 1'b0;
        end else begin
            head_d = head_q;
        end
        if (store_acc_s) begin
            tail_d          = tail_q + PW'(1);
            entry_d[tail_q] = '{valid: 1'b1, addr: AddrIn, data: DataIn};
        end else begin
            tail_d = tail_q;
        end
        case ({store_acc_s, drain_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every pending store
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer (DEPTH=4, 32-bit address/data).
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled on the falling edge, registered occupancy just after the rising edge.
module tb_store_buffer;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clkIn     = 1'b0;
    logic          resetIn   = 1'b1;
    logic          StoreIn   = 1'b0;
    logic          LoadIn    = 1'b0;
    logic [AW-1:0] AddrIn    = '0;
    logic [DW-1:0] DataIn    = '0;
    logic [DW-1:0] MemDataIn = '0;
    logic          StallOut;
    logic [DW-1:0] LoadDataOut;
    logic          LoadHitOut;
    logic          EmptyOut;
    logic [AW-1:0] MemAddrOut;
    logic [DW-1:0] MemDataOut;
    logic          MemWriteOut;
    logic          MemReadOut;

    int errors = 0;
    int checks = 0;

    always #5 clkIn = ~clkIn;

    store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clkIn       (clkIn),
        .resetIn     (resetIn),
        .StoreIn     (StoreIn),
        .LoadIn      (LoadIn),
        .AddrIn      (AddrIn),
        .DataIn      (DataIn),
        .StallOut    (StallOut),
        .LoadDataOut (LoadDataOut),
        .LoadHitOut  (LoadHitOut),
        .EmptyOut    (EmptyOut),
        .MemAddrOut  (MemAddrOut),
        .MemDataOut  (MemDataOut),
        .MemWriteOut (MemWriteOut),
        .MemReadOut  (MemReadOut),
        .MemDataIn   (MemDataIn)
    );

    task automatic cyc();
        @(posedge clkIn);
        #1;
    endtask

    task automatic idle();
        StoreIn   = 1'b0;
        LoadIn    = 1'b0;
        AddrIn    = '0;
        DataIn    = '0;
        MemDataIn = '0;
    endtask

    task automatic drive(input logic s, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
        StoreIn = s;
        LoadIn  = l;
        AddrIn  = a;
        DataIn  = d;
    endtask

    task automatic do_reset();
        idle();
        resetIn = 1'b1;
        cyc();
        cyc();
        resetIn = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        resetIn = 1'b1;
        cyc();
        @(negedge clkIn);
        checks++;
        if ({StallOut, EmptyOut, MemWriteOut, MemReadOut, LoadHitOut} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_during: got stall/empty/wr/rd/hit=%b want 01000",
                     {StallOut, EmptyOut, MemWriteOut, MemReadOut, LoadHitOut});
        end
        cyc();
        resetIn = 1'b0;
        @(negedge clkIn);
        checks++;
        if ({StallOut, EmptyOut, MemWriteOut, MemReadOut, LoadHitOut} !== 5'b01000 ||
            MemAddrOut !== 32'h0 || MemDataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_after: got flags=%b addr=%h data=%h want 01000 0 0",
                     {StallOut, EmptyOut, MemWriteOut, MemReadOut, LoadHitOut}, MemAddrOut, MemDataOut);
        end
        cyc();
    endtask

    task automatic test_single_store();
        do_reset();
        drive(1'b1, 1'b0, 32'h10, 32'hAA);
        @(negedge clkIn);
        checks++;
        if (MemWriteOut !== 1'b0 || EmptyOut !== 1'b1) begin
            errors++;
            $display("FAIL store_not_direct: got wr=%b empty=%b want 0 1", MemWriteOut, EmptyOut);
        end
        cyc();
        idle();
        @(negedge clkIn);
        checks++;
        if (MemWriteOut !== 1'b1 || MemAddrOut !== 32'h10 || MemDataOut !== 32'hAA || EmptyOut !== 1'b0) begin
            errors++;
            $display("FAIL store_drain: got wr=%b addr=%h data=%h empty=%b want 1 10 aa 0",
                     MemWriteOut, MemAddrOut, MemDataOut, EmptyOut);
        end
        cyc();
        @(negedge clkIn);
        checks++;
        if (EmptyOut !== 1'b1 || MemWriteOut !== 1'b0 || MemAddrOut !== 32'h0) begin
            errors++;
            $display("FAIL store_empty_after: got empty=%b wr=%b addr=%h want 1 0 0",
                     EmptyOut, MemWriteOut, MemAddrOut);
        end
        cyc();
    endtask

    task automatic test_forward();
        do_reset();
        drive(1'b1, 1'b1, 32'h4, 32'h1);
        cyc();
        drive(1'b1, 1'b1, 32'h4, 32'h2);
        @(negedge clkIn);
        checks++;
        if (LoadHitOut !== 1'b0 || MemWriteOut !== 1'b0) begin
            errors++;
            $display("FAIL fwd_store_and_load: got hit=%b wr=%b want 0 0", LoadHitOut, MemWriteOut);
        end
        cyc();
        drive(1'b0, 1'b1, 32'h4, 32'h0);
        MemDataIn = 32'h99;
        @(negedge clkIn);
        checks++;
        if (LoadHitOut !== 1'b1 || LoadDataOut !== 32'h2 || MemWriteOut !== 1'b0) begin
            errors++;
            $display("FAIL fwd_youngest: got hit=%b data=%h wr=%b want 1 2 0", LoadHitOut, LoadDataOut, MemWriteOut);
        end
        cyc();
        idle();
        for (int k = 1; k <= 2; k++) begin
            @(negedge clkIn);
            checks++;
            if (MemWriteOut !== 1'b1 || MemDataOut !== DW'(k)) begin
                errors++;
                $display("FAIL fwd_drain_order: got wr=%b data=%h want 1 %h", MemWriteOut, MemDataOut, k);
            end
            cyc();
        end
        @(negedge clkIn);
        checks++;
        if (EmptyOut !== 1'b1) begin
            errors++;
            $display("FAIL fwd_empty: got %b want 1", EmptyOut);
        end
        cyc();
    endtask

    task automatic test_full_stall();
        logic [AW-1:0] exp_a [4];
        logic [DW-1:0] exp_d [4];
        exp_a = '{32'h102, 32'h103, 32'h104, 32'h200};
        exp_d = '{32'hD2, 32'hD3, 32'hD4, 32'hE0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h100 + AW'(i), 32'hD0 + DW'(i));
            cyc();
        end
        drive(1'b0, 1'b1, 32'h300, 32'h0);
        @(negedge clkIn);
        checks++;
        if (StallOut !== 1'b1 || MemReadOut !== 1'b0 || MemWriteOut !== 1'b1 ||
            MemAddrOut !== 32'h100 || MemDataOut !== 32'hD0) begin
            errors++;
            $display("FAIL full_load_stall: got stall=%b rd=%b wr=%b addr=%h data=%h want 1 0 1 100 d0",
                     StallOut, MemReadOut, MemWriteOut, MemAddrOut, MemDataOut);
        end
        cyc();
        checks++;
        if (dut.count_q !== 3'd3) begin
            errors++;
            $display("FAIL full_load_count: got %0d want 3", dut.count_q);
        end
        drive(1'b1, 1'b1, 32'h104, 32'hD4);
        cyc();
        drive(1'b1, 1'b1, 32'h200, 32'hE0);
        @(negedge clkIn);
        checks++;
        if (StallOut !== 1'b1 || MemWriteOut !== 1'b1 || MemAddrOut !== 32'h101) begin
            errors++;
            $display("FAIL fifth_store_stall: got stall=%b wr=%b addr=%h want 1 1 101", StallOut, MemWriteOut, MemAddrOut);
        end
        cyc();
        checks++;
        if (dut.count_q !== 3'd3) begin
            errors++;
            $display("FAIL fifth_store_count: got %0d want 3", dut.count_q);
        end
        @(negedge clkIn);
        checks++;
        if (StallOut !== 1'b0 || MemWriteOut !== 1'b0) begin
            errors++;
            $display("FAIL retry_accept: got stall=%b wr=%b want 0 0", StallOut, MemWriteOut);
        end
        cyc();
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clkIn);
            checks++;
            if (MemWriteOut !== 1'b1 || MemAddrOut !== exp_a[k] || MemDataOut !== exp_d[k]) begin
                errors++;
                $display("FAIL full_drain_order: got wr=%b addr=%h data=%h want 1 %h %h",
                         MemWriteOut, MemAddrOut, MemDataOut, exp_a[k], exp_d[k]);
            end
            cyc();
        end
        @(negedge clkIn);
        checks++;
        if (EmptyOut !== 1'b1) begin
            errors++;
            $display("FAIL full_empty: got %b want 1", EmptyOut);
        end
        cyc();
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b0, 32'h30, 32'h11);
        cyc();
        drive(1'b1, 1'b1, 32'h31, 32'h12);
        cyc();
        for (int k = 2; k < 8; k++) begin
            drive(1'b1, 1'b0, 32'h30 + AW'(k), 32'h11 + DW'(k));
            @(negedge clkIn);
            checks++;
            if (MemWriteOut !== 1'b1 || MemAddrOut !== 32'h30 + AW'(k - 2) || MemDataOut !== 32'h11 + DW'(k - 2)) begin
                errors++;
                $display("FAIL wrap_drain: got wr=%b addr=%h data=%h want 1 %h %h",
                         MemWriteOut, MemAddrOut, MemDataOut, 32'h30 + k - 2, 32'h11 + k - 2);
            end
            cyc();
            checks++;
            if (dut.count_q !== 3'd2) begin
                errors++;
                $display("FAIL wrap_count: got %0d want 2", dut.count_q);
            end
        end
        idle();
        for (int k = 6; k < 8; k++) begin
            @(negedge clkIn);
            checks++;
            if (MemWriteOut !== 1'b1 || MemDataOut !== 32'h11 + DW'(k)) begin
                errors++;
                $display("FAIL wrap_tail: got wr=%b data=%h want 1 %h", MemWriteOut, MemDataOut, 32'h11 + k);
            end
            cyc();
        end
        @(negedge clkIn);
        checks++;
        if (EmptyOut !== 1'b1 || MemWriteOut !== 1'b0) begin
            errors++;
            $display("FAIL wrap_empty: got empty=%b wr=%b want 1 0", EmptyOut, MemWriteOut);
        end
        cyc();
    endtask

    task automatic test_load_miss();
        do_reset();
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        MemDataIn = 32'h55;
        @(negedge clkIn);
        checks++;
        if (MemReadOut !== 1'b1 || LoadHitOut !== 1'b0 || LoadDataOut !== 32'h55 ||
            MemWriteOut !== 1'b0 || MemAddrOut !== 32'h20) begin
            errors++;
            $display("FAIL load_miss_empty: got rd=%b hit=%b data=%h wr=%b addr=%h want 1 0 55 0 20",
                     MemReadOut, LoadHitOut, LoadDataOut, MemWriteOut, MemAddrOut);
        end
        cyc();
        drive(1'b1, 1'b1, 32'h40, 32'h77);
        cyc();
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge clkIn);
        checks++;
        if (LoadHitOut !== 1'b0 || LoadDataOut !== 32'h55 || MemWriteOut !== 1'b0) begin
            errors++;
            $display("FAIL load_miss_pending: got hit=%b data=%h wr=%b want 0 55 0", LoadHitOut, LoadDataOut, MemWriteOut);
        end
        cyc();
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        @(negedge clkIn);
        checks++;
        if (LoadHitOut !== 1'b1 || LoadDataOut !== 32'h77) begin
            errors++;
            $display("FAIL load_hit: got hit=%b data=%h want 1 77", LoadHitOut, LoadDataOut);
        end
        cyc();
        idle();
        cyc();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h50 + AW'(i), 32'h60 + DW'(i));
            cyc();
        end
        idle();
        resetIn = 1'b1;
        @(negedge clkIn);
        checks++;
        if (MemWriteOut !== 1'b1 || MemAddrOut !== 32'h50) begin
            errors++;
            $display("FAIL mid_drain_active: got wr=%b addr=%h want 1 50", MemWriteOut, MemAddrOut);
        end
        cyc();
        resetIn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clkIn);
            checks++;
            if (EmptyOut !== 1'b1 || MemWriteOut !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard: got empty=%b wr=%b want 1 0", EmptyOut, MemWriteOut);
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_forward();
        test_full_stall();
        test_wrap();
        test_load_miss();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
